// File: rtl/csa_serial_add_ctrl.sv
// Wide add/subtract sequencer: one CHUNK_W-bit carry-select slice is reused over
// NUM_CHUNKS cycles, with the inter-chunk carry held in a register.

module csa_slice #(
    parameter int W = 13
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    localparam int LO = W / 2;
    localparam int HI = W - LO;

    logic [LO:0] lo;
    logic [HI:0] hi0, hi1;

    assign lo  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, cin};
    // Upper half is precomputed for both possible carries and selected by the lower carry.
    assign hi0 = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]};
    assign hi1 = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]} + {{HI{1'b0}}, 1'b1};

    assign s    = {(lo[LO] ? hi1[HI-1:0] : hi0[HI-1:0]), lo[LO-1:0]};
    assign cout = lo[LO] ? hi1[HI] : hi0[HI];
endmodule

module csa_serial_add_ctrl #(
    parameter int CHUNK_W    = 13,
    parameter int NUM_CHUNKS = 4,
    parameter int CNT_W      = 2,
    localparam int W         = CHUNK_W * NUM_CHUNKS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_add_term1,
    input  logic [W-1:0] i_add_term2,
    input  logic         i_sub,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         busy
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                                 state_q, state_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic                                   carry_q, carry_d;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                                   cout_q, cout_d, ovf_q, ovf_d, vld_q, vld_d;

    logic [CHUNK_W-1:0] sl_s;
    logic               sl_c;
    logic               last;

    csa_slice #(.W(CHUNK_W)) u_slice (
        .a    (a_q[cnt_q]),
        .b    (b_q[cnt_q]),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_c)
    );

    assign last    = (cnt_q == CNT_W'(NUM_CHUNKS - 1));
    assign o_ready = (state_q == S_IDLE) & ~rst;
    assign busy    = (state_q != S_IDLE);
    assign o_valid = vld_q;
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign ovf     = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        vld_d   = vld_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid && o_ready) begin
                    // Subtraction folds into A + ~B with the initial carry set.
                    a_d     = i_add_term1;
                    b_d     = i_add_term2 ^ {W{i_sub}};
                    carry_d = i_sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[cnt_q] = sl_s;
                carry_d      = sl_c;
                cnt_d        = cnt_q + CNT_W'(1);
                if (last) begin
                    cout_d  = sl_c;
                    ovf_d   = (a_q[NUM_CHUNKS-1][CHUNK_W-1] == b_q[NUM_CHUNKS-1][CHUNK_W-1]) &
                              (sl_s[CHUNK_W-1] != a_q[NUM_CHUNKS-1][CHUNK_W-1]);
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end
endmodule
